// File: rtl/bram_port_arbiter_if.sv
// Bundle of requester-side and BRAM-side signals owned by the frame-buffer port arbiter.
// slave = arbiter view, master = requesters plus BRAM primitive view.
interface bram_port_arbiter_if #(
    parameter int unsigned ADDR_W = 14
);
    logic              WR_REQ;
    logic [ADDR_W-1:0] WR_ADDR;
    logic [7:0]        WR_DATA;
    logic              WR_READY;
    logic              RD_REQ;
    logic [ADDR_W-1:0] RD_ADDR;
    logic              RD_ACK;
    logic [7:0]        RD_DATA;
    logic              RD_VALID;
    logic [ADDR_W-1:0] BRAM_ADDR;
    logic [7:0]        BRAM_DIN;
    logic              BRAM_WE;
    logic [7:0]        BRAM_DOUT;
    logic              OVERFLOW;

    modport slave (
        input  WR_REQ, WR_ADDR, WR_DATA, RD_REQ, RD_ADDR, BRAM_DOUT,
        output WR_READY, RD_ACK, RD_DATA, RD_VALID, BRAM_ADDR, BRAM_DIN, BRAM_WE, OVERFLOW
    );

    modport master (
        output WR_REQ, WR_ADDR, WR_DATA, RD_REQ, RD_ADDR, BRAM_DOUT,
        input  WR_READY, RD_ACK, RD_DATA, RD_VALID, BRAM_ADDR, BRAM_DIN, BRAM_WE, OVERFLOW
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Single-port frame-buffer BRAM arbiter: posted writes through a small FIFO,
// read priority for scan-out, forced write drain when the FIFO is full.
module bram_port_arbiter #(
    parameter int unsigned WFIFO_DEPTH = 4,
    parameter int unsigned ADDR_W      = 14
) (
    input  logic                 O_CLK,
    input  logic                 RST_N,
    bram_port_arbiter_if.slave   bus
);
    localparam int unsigned PTR_W = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(WFIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(WFIFO_DEPTH);

    logic [ADDR_W-1:0] r_fifo_addr [WFIFO_DEPTH];
    logic [7:0]        r_fifo_data [WFIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              r_wr_ready;
    logic              r_rd_pend;
    logic              r_rd_valid;
    logic              r_overflow;
    logic [ADDR_W-1:0] r_bram_addr;
    logic [7:0]        r_bram_din;
    logic              r_bram_we;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_rd_ack;

    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == '0);
    assign w_push  = bus.WR_REQ & r_wr_ready;

    // One BRAM op per cycle: full FIFO beats reads, reads beat ordinary drain.
    always_comb begin
        w_pop    = 1'b0;
        w_rd_ack = 1'b0;
        if (w_full) begin
            w_pop = 1'b1;
        end else if (bus.RD_REQ) begin
            w_rd_ack = 1'b1;
        end else if (!w_empty) begin
            w_pop = 1'b1;
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage carries no reset; occupancy and pointers define validity.
    always_ff @(posedge O_CLK) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= bus.WR_ADDR;
            r_fifo_data[r_wr_ptr] <= bus.WR_DATA;
        end
    end

    always_ff @(posedge O_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wr_ready <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count    <= w_count_nxt;
            r_wr_ready <= (w_count_nxt != DEPTH_C);
            r_overflow <= r_overflow | (bus.WR_REQ & ~r_wr_ready);
        end
    end

    // BRAM control pins; address and data hold while idle.
    always_ff @(posedge O_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_bram_addr <= '0;
            r_bram_din  <= '0;
            r_bram_we   <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_bram_we  <= w_pop;
            r_rd_pend  <= w_rd_ack;
            r_rd_valid <= r_rd_pend;
            if (w_pop) begin
                r_bram_addr <= r_fifo_addr[r_rd_ptr];
                r_bram_din  <= r_fifo_data[r_rd_ptr];
            end else if (w_rd_ack) begin
                r_bram_addr <= bus.RD_ADDR;
            end
        end
    end

    assign bus.WR_READY  = r_wr_ready;
    assign bus.RD_ACK    = w_rd_ack;
    assign bus.RD_DATA   = bus.BRAM_DOUT;
    assign bus.RD_VALID  = r_rd_valid;
    assign bus.BRAM_ADDR = r_bram_addr;
    assign bus.BRAM_DIN  = r_bram_din;
    assign bus.BRAM_WE   = r_bram_we;
    assign bus.OVERFLOW  = r_overflow;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a behavioural read-first BRAM model.
module tb_bram_port_arbiter;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errs;

    bram_port_arbiter_if #(.ADDR_W(14)) bus ();

    bram_port_arbiter #(.WFIFO_DEPTH(4), .ADDR_W(14)) u_dut (
        .O_CLK (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [16384];

    // Read-first synchronous BRAM
    always @(posedge clk) begin
        bus.BRAM_DOUT = mem[bus.BRAM_ADDR];
        if (bus.BRAM_WE) mem[bus.BRAM_ADDR] = bus.BRAM_DIN;
    end

    logic [21:0] wr_log [$];
    logic [7:0]  rd_log [$];

    always @(posedge clk) if (bus.BRAM_WE === 1'b1) wr_log.push_back({bus.BRAM_ADDR, bus.BRAM_DIN});
    always @(negedge clk) if (bus.RD_VALID === 1'b1) rd_log.push_back(bus.RD_DATA);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [13:0] a, output logic [7:0] d);
        int n;
        bool_ack: begin end
        d = 8'hxx;
        bus.RD_REQ  = 1'b1;
        bus.RD_ADDR = a;
        n = 0;
        @(negedge clk);
        while (bus.RD_ACK !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("rd_ack_timeout", 32'(n), 32'(0));
        tick();
        bus.RD_REQ = 1'b0;
        n = 0;
        @(negedge clk);
        while (bus.RD_VALID !== 1'b1 && n < 5) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5) check("rd_valid_timeout", 32'(n), 32'(0));
        else d = bus.RD_DATA;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        n_checks = 0;
        n_errs   = 0;
        for (int i = 0; i < 16384; i++) mem[i] = 8'(i) ^ 8'h3C;
        mem[14'h3FFF] = 8'h5A;
        rst_n       = 1'b0;
        bus.WR_REQ  = 1'b0;
        bus.WR_ADDR = '0;
        bus.WR_DATA = '0;
        bus.RD_REQ  = 1'b0;
        bus.RD_ADDR = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_wr_ready", 32'(bus.WR_READY), 32'(0));
        check("rst_we", 32'(bus.BRAM_WE), 32'(0));
        check("rst_addr", 32'(bus.BRAM_ADDR), 32'(0));
        check("rst_din", 32'(bus.BRAM_DIN), 32'(0));
        check("rst_rd_valid", 32'(bus.RD_VALID), 32'(0));
        check("rst_overflow", 32'(bus.OVERFLOW), 32'(0));
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check("wr_ready_after_rst", 32'(bus.WR_READY), 32'(1));

        // Single write, no reads
        tick();
        wr_log.delete();
        bus.WR_REQ  = 1'b1;
        bus.WR_ADDR = 14'h0123;
        bus.WR_DATA = 8'hA5;
        tick();
        bus.WR_REQ = 1'b0;
        @(negedge clk);
        check("t1_we_early", 32'(bus.BRAM_WE), 32'(0));
        tick();
        @(negedge clk);
        check("t1_we", 32'(bus.BRAM_WE), 32'(1));
        check("t1_addr", 32'(bus.BRAM_ADDR), 32'h0123);
        check("t1_din", 32'(bus.BRAM_DIN), 32'hA5);
        tick();
        @(negedge clk);
        check("t1_we_after", 32'(bus.BRAM_WE), 32'(0));
        check("t1_wlog_size", 32'(wr_log.size()), 32'(1));
        check("t1_wr_ready", 32'(bus.WR_READY), 32'(1));

        // Single read with exact latency
        tick();
        bus.RD_REQ  = 1'b1;
        bus.RD_ADDR = 14'h3FFF;
        @(negedge clk);
        check("t2_ack", 32'(bus.RD_ACK), 32'(1));
        tick();
        bus.RD_REQ = 1'b0;
        @(negedge clk);
        check("t2_valid_early", 32'(bus.RD_VALID), 32'(0));
        check("t2_bram_addr", 32'(bus.BRAM_ADDR), 32'h3FFF);
        tick();
        @(negedge clk);
        check("t2_valid", 32'(bus.RD_VALID), 32'(1));
        check("t2_data", 32'(bus.RD_DATA), 32'h5A);
        tick();
        @(negedge clk);
        check("t2_valid_once", 32'(bus.RD_VALID), 32'(0));

        // Read-priority fill: four writes under continuous reads
        tick();
        wr_log.delete();
        bus.RD_REQ  = 1'b1;
        bus.RD_ADDR = 14'h0200;
        for (int i = 0; i < 4; i++) begin
            bus.WR_REQ  = 1'b1;
            bus.WR_ADDR = 14'h0100 + 14'(i);
            bus.WR_DATA = 8'(8'h11 * (i + 1));
            tick();
        end
        bus.WR_REQ = 1'b0;
        @(negedge clk);
        check("t3_ready_full", 32'(bus.WR_READY), 32'(0));
        check("t3_ack_blocked", 32'(bus.RD_ACK), 32'(0));
        tick();
        @(negedge clk);
        check("t3_drain_we", 32'(bus.BRAM_WE), 32'(1));
        check("t3_drain_addr", 32'(bus.BRAM_ADDR), 32'h0100);
        check("t3_drain_din", 32'(bus.BRAM_DIN), 32'h11);
        check("t3_ack_resume", 32'(bus.RD_ACK), 32'(1));
        check("t3_ready_back", 32'(bus.WR_READY), 32'(1));
        tick();
        bus.RD_REQ = 1'b0;
        repeat (6) tick();
        check("t3_wlog_size", 32'(wr_log.size()), 32'(4));
        for (int i = 0; i < 4 && i < wr_log.size(); i++)
            check($sformatf("t3_order%0d", i), 32'(wr_log[i]),
                  32'({14'h0100 + 14'(i), 8'(8'h11 * (i + 1))}));

        // Overflow: fifth beat offered while not ready
        wr_log.delete();
        bus.RD_REQ  = 1'b1;
        bus.RD_ADDR = 14'h0300;
        for (int i = 0; i < 5; i++) begin
            bus.WR_REQ  = 1'b1;
            bus.WR_ADDR = 14'h0200 + 14'(i);
            bus.WR_DATA = 8'h60 + 8'(i);
            tick();
        end
        bus.WR_REQ = 1'b0;
        @(negedge clk);
        check("t4_overflow", 32'(bus.OVERFLOW), 32'(1));
        tick();
        bus.RD_REQ = 1'b0;
        repeat (6) tick();
        check("t4_overflow_sticky", 32'(bus.OVERFLOW), 32'(1));
        check("t4_wlog_size", 32'(wr_log.size()), 32'(4));
        for (int i = 0; i < 4 && i < wr_log.size(); i++)
            check($sformatf("t4_order%0d", i), 32'(wr_log[i]),
                  32'({14'h0200 + 14'(i), 8'h60 + 8'(i)}));
        check("t4_dropped_untouched", 32'(mem[14'h0204]), 32'h38);

        // Stale read before drain, fresh read after
        rd_log.delete();
        bus.RD_REQ  = 1'b1;
        bus.RD_ADDR = 14'h0010;
        bus.WR_REQ  = 1'b1;
        bus.WR_ADDR = 14'h0010;
        bus.WR_DATA = 8'h77;
        tick();
        bus.WR_REQ = 1'b0;
        tick();
        tick();
        bus.RD_REQ = 1'b0;
        repeat (6) tick();
        check("t5_rlog_size", 32'(rd_log.size()), 32'(3));
        if (rd_log.size() >= 3) begin
            check("t5_stale0", 32'(rd_log[0]), 32'h2C);
            check("t5_stale2", 32'(rd_log[2]), 32'h2C);
        end
        do_read(14'h0010, d);
        check("t5_fresh", 32'(d), 32'h77);

        // Mid-operation reset with queued writes and a live read grant
        tick();
        bus.RD_REQ  = 1'b1;
        bus.RD_ADDR = 14'h0400;
        for (int i = 0; i < 3; i++) begin
            bus.WR_REQ  = 1'b1;
            bus.WR_ADDR = 14'h0500 + 14'(i);
            bus.WR_DATA = 8'hC0 + 8'(i);
            tick();
        end
        bus.WR_REQ = 1'b0;
        @(negedge clk);
        check("t6_ack_before_rst", 32'(bus.RD_ACK), 32'(1));
        #1;
        rst_n = 1'b0;
        wr_log.delete();
        rd_log.delete();
        #1;
        check("t6_we", 32'(bus.BRAM_WE), 32'(0));
        check("t6_addr", 32'(bus.BRAM_ADDR), 32'(0));
        check("t6_din", 32'(bus.BRAM_DIN), 32'(0));
        check("t6_rd_valid", 32'(bus.RD_VALID), 32'(0));
        check("t6_overflow", 32'(bus.OVERFLOW), 32'(0));
        check("t6_wr_ready", 32'(bus.WR_READY), 32'(0));
        bus.RD_REQ = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) tick();
        check("t6_no_writes", 32'(wr_log.size()), 32'(0));
        check("t6_no_reads", 32'(rd_log.size()), 32'(0));
        check("t6_ready_after", 32'(bus.WR_READY), 32'(1));
        check("t6_overflow_after", 32'(bus.OVERFLOW), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
